// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the dual-mode INT/FP16 arithmetic blocks.
// Classification flushes subnormals to ZERO so datapaths never see them.
package fp16_pkg;

   localparam int          FP16_BIAS    = 15;
   localparam logic [15:0] FP16_QNAN    = 16'h7E00;
   localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;

   typedef enum logic [1:0] {
      ZERO,
      NORM,
      INF,
      NAN
   } fp16_class_e;

   function automatic fp16_class_e fp16_class(input logic [15:0] x);
      fp16_class_e cls;
      cls = NORM;
      if (x[14:10] == 5'd0)
         cls = ZERO;
      else if (x[14:10] == FP16_EXP_MAX)
         cls = (x[9:0] == 10'd0) ? INF : NAN;
      return cls;
   endfunction

endpackage

// File: rtl/mul_nbit.sv
// Unsigned n x n array multiplier: sum of shifted partial products.
module mul_nbit #(
   parameter int n = 8
) (
   input  logic [n-1:0]   a,
   input  logic [n-1:0]   b,
   output logic [2*n-1:0] p
);

   always_comb begin
      p = '0;
      for (int i = 0; i < n; i++) begin
         if (b[i])
            p = p + ({{n{1'b0}}, a} << i);
      end
   end

endmodule

// File: rtl/int_fp_mul.sv
// Three-stage dual-mode multiplier: signed INT8 x INT8 or FP16 x FP16 (truncating),
// S1 unpack/classify, S2 multiply, S3 normalize/pack, behind a valid/ready stream.
module int_fp_mul
   import fp16_pkg::*;
#(
   parameter int STAGES = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        mode,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] c,
   output logic        out_mode
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high. The stall is global (output held, not taken) and freezes every
   // stage including empty ones; in_ready is its combinational inverse.
   logic [STAGES-1:0] vld;
   logic              stall;

   assign out_valid = vld[STAGES-1];
   assign stall     = vld[STAGES-1] & ~out_ready;
   assign in_ready  = ~stall;

   // S1 state
   logic              mode1, fsgn1, isgn1;
   fp16_class_e       cls_a1, cls_b1;
   logic signed [6:0] e1;
   logic [10:0]       ma1, mb1;
   logic [7:0]        mag_a1, mag_b1;

   // S2 state
   logic              mode2, fsgn2;
   fp16_class_e       cls_a2, cls_b2;
   logic signed [6:0] e2;
   logic [21:0]       p2;
   logic [15:0]       ip2;

   logic [21:0]       p_mant;
   logic [15:0]       p_int;
   logic signed [6:0] e_n;
   logic [9:0]        mant;
   logic [15:0]       res;
   logic              unused_p_lo;

   mul_nbit #(.n(11)) u_mul_mant (
      .a (ma1),
      .b (mb1),
      .p (p_mant)
   );

   mul_nbit #(.n(8)) u_mul_int (
      .a (mag_a1),
      .b (mag_b1),
      .p (p_int)
   );

   // Only the top 12 product bits matter under truncation.
   assign unused_p_lo = ^p2[9:0];

   always_comb begin
      e_n  = e2;
      mant = p2[19:10];
      if (p2[21]) begin
         e_n  = e2 + 7'sd1;
         mant = p2[20:11];
      end
      res = {fsgn2, e_n[4:0], mant};
      if (!mode2)
         res = ip2;
      else if (cls_a2 == NAN || cls_b2 == NAN ||
               (cls_a2 == INF && cls_b2 == ZERO) || (cls_a2 == ZERO && cls_b2 == INF))
         res = FP16_QNAN;
      else if (cls_a2 == INF || cls_b2 == INF)
         res = {fsgn2, FP16_EXP_MAX, 10'd0};
      else if (cls_a2 == ZERO || cls_b2 == ZERO || e_n <= 7'sd0)
         res = {fsgn2, 15'd0};
      else if (e_n >= 7'sd31)
         res = {fsgn2, FP16_EXP_MAX, 10'd0};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld      <= '0;
         mode1    <= 1'b0;
         fsgn1    <= 1'b0;
         isgn1    <= 1'b0;
         cls_a1   <= ZERO;
         cls_b1   <= ZERO;
         e1       <= '0;
         ma1      <= '0;
         mb1      <= '0;
         mag_a1   <= '0;
         mag_b1   <= '0;
         mode2    <= 1'b0;
         fsgn2    <= 1'b0;
         cls_a2   <= ZERO;
         cls_b2   <= ZERO;
         e2       <= '0;
         p2       <= '0;
         ip2      <= '0;
         c        <= '0;
         out_mode <= 1'b0;
      end else if (!stall) begin
         vld    <= {vld[STAGES-2:0], in_valid};
         // S1: unpack and classify
         mode1  <= mode;
         fsgn1  <= a[15] ^ b[15];
         isgn1  <= a[7] ^ b[7];
         cls_a1 <= fp16_class(a);
         cls_b1 <= fp16_class(b);
         e1     <= $signed({2'b00, a[14:10]}) + $signed({2'b00, b[14:10]})
                   - $signed(7'(FP16_BIAS));
         ma1    <= {1'b1, a[9:0]};
         mb1    <= {1'b1, b[9:0]};
         mag_a1 <= a[7] ? (8'd0 - a[7:0]) : a[7:0];
         mag_b1 <= b[7] ? (8'd0 - b[7:0]) : b[7:0];
         // S2: multiply
         mode2  <= mode1;
         fsgn2  <= fsgn1;
         cls_a2 <= cls_a1;
         cls_b2 <= cls_b1;
         e2     <= e1;
         p2     <= p_mant;
         ip2    <= isgn1 ? (16'd0 - p_int) : p_int;
         // S3: normalize and pack
         c        <= res;
         out_mode <= mode2;
      end
   end

endmodule

// File: tb/tb_int_fp_mul.sv
// Self-checking bench for int_fp_mul: directed known answers, backpressure,
// mid-stream reset and a random stream against a behavioural reference.
module tb_int_fp_mul;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        mode = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] c;
   logic        out_mode;

   logic [16:0] exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic        prev_stall = 1'b0;
   logic [16:0] prev_out = '0;

   int_fp_mul #(.STAGES(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c),
      .out_mode  (out_mode)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // reference model
   function automatic logic [15:0] ref_mul(input logic m, input logic [15:0] x, input logic [15:0] y);
      logic signed [7:0] sx, sy;
      int     prod, ex, ey, fx, fy, e, fr;
      longint p;
      logic   s;
      if (!m) begin
         sx   = x[7:0];
         sy   = y[7:0];
         prod = sx * sy;
         return prod[15:0];
      end
      s  = x[15] ^ y[15];
      ex = x[14:10];
      ey = y[14:10];
      fx = x[9:0];
      fy = y[9:0];
      if ((ex == 31 && fx != 0) || (ey == 31 && fy != 0)) return 16'h7E00;
      if ((ex == 31 && ey == 0) || (ey == 31 && ex == 0)) return 16'h7E00;
      if (ex == 31 || ey == 31) return {s, 15'h7C00};
      if (ex == 0 || ey == 0) return {s, 15'h0000};
      p = longint'(1024 + fx) * longint'(1024 + fy);
      e = ex + ey - 15;
      if (p >= 2097152) begin
         fr = int'((p >> 11) & 1023);
         e  = e + 1;
      end else begin
         fr = int'((p >> 10) & 1023);
      end
      if (e >= 31) return {s, 15'h7C00};
      if (e <= 0) return {s, 15'h0000};
      return {s, 5'(e), 10'(fr)};
   endfunction

   // scoreboard: sample at negedge, i.e. what the next rising edge will transfer
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         check("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
         if (prev_stall) begin
            check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
            check("stall_hold_data", {15'd0, out_mode, c}, {15'd0, prev_out});
         end
         if (out_valid) begin
            check("stale_product", {31'd0, exp_q.size() != 0}, 32'd1);
            if (out_ready && exp_q.size() != 0)
               check("product", {15'd0, out_mode, c}, {15'd0, exp_q.pop_front()});
         end
         if (in_valid && in_ready)
            exp_q.push_back({mode, ref_mul(mode, a, b)});
         prev_stall = out_valid && !out_ready;
         prev_out   = {out_mode, c};
      end
   end

   // driver tasks (entered and left 1 time unit after a rising edge)
   task automatic send_pair(input logic m, input logic [15:0] x, input logic [15:0] y);
      int   t = 0;
      logic ok = 1'b0;
      mode = m; a = x; b = y; in_valid = 1'b1;
      while (!ok && t < 50) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk); #1;
         t++;
      end
      check("send_accept", {31'd0, ok}, 32'd1);
   endtask

   // one pair into an empty pipeline; counts cycles from presenting it to out_valid
   task automatic issue_one(input string tag, input logic m, input logic [15:0] x,
                            input logic [15:0] y, input logic [15:0] expc);
      int n = 1;
      out_ready = 1'b1;
      mode = m; a = x; b = y; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_latency"}, n, 32'd3);
      check(tag, {16'd0, c}, {16'd0, expc});
      check({tag, "_mode"}, {31'd0, out_mode}, {31'd0, m});
      @(posedge clk); #1;
   endtask

   task automatic rand_pair();
      mode = 1'($urandom_range(0, 1));
      a    = 16'($urandom);
      b    = 16'($urandom);
      if ($urandom_range(0, 1) == 0) a[14:10] = 5'($urandom_range(8, 22));
      if ($urandom_range(0, 1) == 0) b[14:10] = 5'($urandom_range(8, 22));
      if ($urandom_range(0, 7) == 0) a[14:10] = ($urandom_range(0, 1) != 0) ? 5'h1F : 5'h00;
      if ($urandom_range(0, 7) == 0) b[14:10] = ($urandom_range(0, 1) != 0) ? 5'h1F : 5'h00;
   endtask

   initial begin
      int   t;
      int   sent;
      logic acc;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_c", {16'd0, c}, 32'd0);
      check("rst_out_mode", {31'd0, out_mode}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;
      @(posedge clk); #1;

      issue_one("fp_1x2", 1'b1, 16'h3C00, 16'h4000, 16'h4000);
      issue_one("fp_1p5_sq", 1'b1, 16'h3E00, 16'h3E00, 16'h4080);
      issue_one("int_neg", 1'b0, 16'hA5FD, 16'h0007, 16'hFFEB);
      issue_one("int_min_sq", 1'b0, 16'h0080, 16'h0080, 16'h4000);
      issue_one("fp_overflow", 1'b1, 16'h7BFF, 16'h7BFF, 16'h7C00);
      issue_one("fp_underflow", 1'b1, 16'h0400, 16'h0400, 16'h0000);
      issue_one("fp_subnorm_flush", 1'b1, 16'h8001, 16'h3C00, 16'h8000);
      issue_one("fp_inf_x_zero", 1'b1, 16'h7C00, 16'h0000, 16'h7E00);
      issue_one("fp_nan_in", 1'b1, 16'h7E00, 16'h3C00, 16'h7E00);
      issue_one("fp_neg_inf", 1'b1, 16'hFC00, 16'h3C00, 16'hFC00);
      issue_one("fp_neg_zero", 1'b1, 16'h8000, 16'h3C00, 16'h8000);

      // backpressure: four mixed pairs, output held off for 5 cycles
      out_ready = 1'b0;
      fork
         begin
            send_pair(1'b1, 16'h3C00, 16'h4200);
            send_pair(1'b0, 16'h00FF, 16'h0081);
            send_pair(1'b1, 16'hC000, 16'h3800);
            send_pair(1'b0, 16'h007F, 16'h007F);
            in_valid = 1'b0;
         end
         begin
            int w = 0;
            while (!out_valid && w < 20) begin
               @(posedge clk); #1;
               w++;
            end
            check("bp_valid_seen", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      check("bp_drained", exp_q.size(), 32'd0);

      // reset with three products in flight
      out_ready = 1'b0;
      send_pair(1'b1, 16'h3C00, 16'h3C00);
      send_pair(1'b0, 16'h0003, 16'h0005);
      send_pair(1'b1, 16'h4000, 16'h4000);
      in_valid = 1'b0;
      check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      rst = 1'b1;
      #1;
      check("rst_async_valid", {31'd0, out_valid}, 32'd0);
      check("rst_async_c", {16'd0, c}, 32'd0);
      check("rst_async_in_ready", {31'd0, in_ready}, 32'd1);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("post_rst_idle", {31'd0, out_valid}, 32'd0);
      issue_one("post_rst", 1'b1, 16'h4000, 16'h4200, 16'h4600);

      // random stream with random output duty
      sent = 0;
      t    = 0;
      rand_pair();
      in_valid = 1'b1;
      while (sent < 10000 && t < 60000) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         t++;
         if (acc) sent++;
         if (acc || !in_valid) begin
            if (sent < 10000) begin
               rand_pair();
               in_valid = ($urandom_range(0, 7) != 0);
            end else begin
               in_valid = 1'b0;
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("rand_sent", sent, 32'd10000);
      t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      check("rand_drained", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/int_fp_mul.md
# int_fp_mul

Pipelined dual-mode multiplier that produces the products the systolic-array MAC accumulates. It takes the same 16-bit operand words and `mode` encoding as the dual-mode INT/FP16 adder. In INT mode it forms a signed 8×8 product; in FP16 mode it forms an IEEE half-precision product with truncation. Results are delivered over a valid/ready stream to the adder stage.

## Interface
- `STAGES`, 3: pipeline depth. Fixed; it is a parameter only for documentation and assertions.
- `clk  in  1`: the single clock.
- `rst  in  1`: reset, asynchronous and active-high.
- `in_valid  in  1`: operand pair valid.
- `in_ready  out  1`: the multiplier accepts the pair this cycle.
- `mode  in  1`: 0 selects INT8 (`a[7:0]`, `b[7:0]`, signed); 1 selects FP16.
- `a, b  in  16`: operands.
- `out_valid  out  1`: a product is present.
- `out_ready  in  1`: the downstream stage takes the product.
- `c  out  16`: product.
- `out_mode  out  1`: the `mode` the product was issued with.

## Operation
- A transfer occurs when a valid signal and its matching ready signal are both high on a rising edge of `clk`.
- `mode` travels with its operands. Consecutive transfers may mix modes freely.
- INT mode: `c` = sext(`a[7:0]`) × sext(`b[7:0]`), a 16-bit two's-complement result. `a[15:8]` and `b[15:8]` are ignored.
- FP16 mode:
  - Sign = `a[15]` ^ `b[15]`.
  - exp = 0 with frac = 0 is treated as zero. exp = 0 with frac ≠ 0 is subnormal and is flushed to a signed zero on input.
  - Special cases:
    - Any operand NaN → `16'h7E00`.
    - Inf × 0 → `16'h7E00`.
    - Inf × finite nonzero → signed Inf.
    - Zero × finite → signed zero.
  - Normal path:
    - Mantissas are `{1,frac}`, 11 bits each; p = ma × mb, 22 bits.
    - e = ea + eb − 15, computed in 7-bit signed arithmetic.
    - If `p[21]`: mantissa = `p[20:11]` and e = e + 1. Otherwise mantissa = `p[19:10]`.
    - Rounding is truncation.
    - e ≥ 31 → signed Inf (`{s,5'h1F,10'h0}`).
    - e ≤ 0 → signed zero (no subnormal output).
- Pipeline stages:
  - S1: unpack, classify, exponent sum.
  - S2: 11×11 mantissa multiply, and the 8×8 signed multiply for INT mode.
  - S3: normalize, apply special cases, pack.

## Timing
- Latency: 3 cycles from the accepting edge to `out_valid`, provided no stall occurs.
- Throughput: one product per cycle.
- Handshake:
  - Stall is global: stall = `out_valid` & !`out_ready`. During a stall every stage register holds its contents.
  - `in_ready` = !stall. It is combinational from `out_ready`.
  - Pipeline bubbles are not compressed. A stall freezes empty stages too.
  - Once `out_valid` is asserted, `c` and `out_mode` are held stable until the transfer completes.
  - Simultaneous input accept and output retire in the same cycle are allowed; throughput remains one per cycle.
- Reset:
  - While `rst` is asserted: all stage valid bits = 0, `out_valid` = 0, `c` = 0, `out_mode` = 0, and `in_ready` = 1.
  - Reset asserted mid-operation discards every in-flight product. No partial output is produced.
  - The first transfer after reset is the first one accepted with `rst` low.

## Structure
- Shared package `fp16_pkg`:
  - Constants: `FP16_BIAS` = 15, `FP16_QNAN` = `16'h7E00`, `FP16_EXP_MAX` = 5'h1F.
  - Class enum: ZERO, NORM, INF, NAN.
  - Function `fp16_class(x)`.
- Sub-module `mul_nbit #(n)`: an unsigned n×n array multiplier.
  - Instanced at n = 11 for the FP16 mantissa multiply.
  - Instanced at n = 8 on magnitudes for INT mode, with the sign applied afterwards.
- Stage registers live in `int_fp_mul` itself.

## Test plan
- FP basics, no stall: `16'h3C00`×`16'h4000` → `16'h4000`, and `16'h3E00`×`16'h3E00` → `16'h4080`. Each product appears 3 cycles after its accept.
- INT sign handling: mode=0, a=`16'hXXFD`, b=`16'h0007` → `16'hFFEB`. Also a=`16'h0080`, b=`16'h0080` → `16'h4000`.
- FP specials:
  - `16'h7BFF`×`16'h7BFF` → `16'h7C00`.
  - `16'h0400`×`16'h0400` → `16'h0000`.
  - `16'h8001`×`16'h3C00` → `16'h8000`.
  - `16'h7C00`×`16'h0000` → `16'h7E00`.
  - `16'h7E00`×`16'h3C00` → `16'h7E00`.
- Backpressure: issue 4 mixed-mode pairs back-to-back and hold `out_ready` = 0 for 5 cycles. Required:
  - `in_ready` drops in the same cycle as the stall.
  - `c` and `out_mode` stay stable throughout the stall.
  - All 4 products emerge in order with no loss and no duplication.
- Reset mid-stream: assert `rst` for 1 cycle while 3 products are in flight. Required:
  - `out_valid` = 0 immediately, asynchronously.
  - No stale product appears afterwards.
  - The next accepted pair returns after exactly 3 cycles.
- Random streaming: 10k random pairs with random `out_ready` duty, checked against a reference model. Every product must be bit-exact.
